// File: rtl/laser_point_streamer_if.sv
// Bundle of every signal exchanged between laser_point_streamer and its
// environment: the host side (point writes, START, BUSY, results) and the
// laser core side (RST/X/Y out, C1X..C2Y/DONE in).
//   master : the environment (host plus laser core). It drives the writes, START and core results.
//   slave  : the streamer itself.
interface laser_point_streamer_if;
  logic        WEN;
  logic [5:0]  WADDR;
  logic [3:0]  WX;
  logic [3:0]  WY;
  logic        START;
  logic        BUSY;
  logic        LRST;
  logic [3:0]  X;
  logic [3:0]  Y;
  logic [3:0]  C1X;
  logic [3:0]  C1Y;
  logic [3:0]  C2X;
  logic [3:0]  C2Y;
  logic        DONE;
  logic [15:0] RES;
  logic        RES_VALID;
  logic        TIMEOUT;

  modport master (
    output WEN, WADDR, WX, WY, START, C1X, C1Y, C2X, C2Y, DONE,
    input  BUSY, LRST, X, Y, RES, RES_VALID, TIMEOUT
  );

  modport slave (
    input  WEN, WADDR, WX, WY, START, C1X, C1Y, C2X, C2Y, DONE,
    output BUSY, LRST, X, Y, RES, RES_VALID, TIMEOUT
  );
endinterface

// File: rtl/laser_point_streamer.sv
// laser_point_streamer: buffers NPTS host-written (X,Y) points. On START it
// pulses the laser core reset for one cycle, then streams the points on NPTS
// consecutive cycles. It then waits for the core's DONE and captures the two
// circle centres into RES with a one-cycle RES_VALID pulse.
//
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous active-high reset
//   bus  - laser_point_streamer_if.slave. Host side: WEN/WADDR/WX/WY,
//          START, BUSY, RES, RES_VALID, TIMEOUT. Core side: LRST, X, Y,
//          C1X/C1Y/C2X/C2Y, DONE.
//
// Optional feature: define LASER_STREAM_TIMEOUT_EN to give up waiting for
// DONE after TO_CYCLES cycles in WAIT_DONE. This pulses TIMEOUT and returns
// to IDLE. Without it, WAIT_DONE waits indefinitely and TIMEOUT is tied low.
module laser_point_streamer #(
  parameter int NPTS      = 40,
  parameter int TO_CYCLES = 4096
) (
  input  logic                  CLK,
  input  logic                  RST,
  laser_point_streamer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CRST, STREAM, WAIT_DONE} state_t;

  localparam logic [5:0] LAST = 6'(NPTS - 1);

  state_t     state, state_next;
  logic [5:0] idx, idx_next;
  logic       capture;
  logic       expire;

  // Point storage is deliberately outside the reset domain.
  logic [7:0] pts [NPTS];

  always_ff @(posedge CLK) begin
    if (bus.WEN && (state == IDLE) && (bus.WADDR <= LAST))
      pts[bus.WADDR] <= {bus.WX, bus.WY};
  end

`ifdef LASER_STREAM_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  // Held at zero outside WAIT_DONE, so it starts from zero on every entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      to_cnt <= '0;
    else if (state != WAIT_DONE)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end

  // The limit is reached on the TO_CYCLES-th edge spent in WAIT_DONE.
  // A DONE on that same edge takes priority.
  assign expire = (state == WAIT_DONE) && !bus.DONE &&
                  (to_cnt == TW'(TO_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_next = state;
    idx_next   = idx;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.START) state_next = CRST;
      end
      CRST: begin
        state_next = STREAM;
        idx_next   = '0;
      end
      STREAM: begin
        if (idx == LAST) state_next = WAIT_DONE;
        else             idx_next   = idx + 6'd1;
      end
      WAIT_DONE: begin
        if (bus.DONE) begin
          capture    = 1'b1;
          state_next = IDLE;
        end else if (expire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state. This makes each output line
  // up with the state it belongs to in the same cycle. LRST therefore sits
  // in CRST, and point k appears in the k-th STREAM cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      idx           <= '0;
      bus.BUSY      <= 1'b0;
      bus.LRST      <= 1'b1;
      bus.X         <= '0;
      bus.Y         <= '0;
      bus.RES       <= '0;
      bus.RES_VALID <= 1'b0;
      bus.TIMEOUT   <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      bus.BUSY <= (state_next != IDLE);
      bus.LRST <= (state_next == CRST);
      if (state_next == STREAM) begin
        bus.X <= pts[idx_next][7:4];
        bus.Y <= pts[idx_next][3:0];
      end else begin
        bus.X <= '0;
        bus.Y <= '0;
      end
      if (capture)
        bus.RES <= {bus.C1X, bus.C1Y, bus.C2X, bus.C2Y};
      bus.RES_VALID <= capture;
      bus.TIMEOUT   <= expire;
    end
  end

endmodule

// File: tb/tb_laser_point_streamer.sv
module tb_laser_point_streamer;
  localparam int NPTS = 40;
`ifdef LASER_STREAM_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  laser_point_streamer_if bus ();

  laser_point_streamer #(.NPTS(NPTS), .TO_CYCLES(TO)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the buffer holds and what RES should show.
  logic [3:0]  mx [NPTS];
  logic [3:0]  my [NPTS];
  logic [15:0] exp_res;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Host write in IDLE; the model applies the address-range rule.
  task automatic write_point(input int a, input logic [3:0] x, input logic [3:0] y);
    bus.WEN   = 1'b1;
    bus.WADDR = 6'(a);
    bus.WX    = x;
    bus.WY    = y;
    tick();
    bus.WEN   = 1'b0;
    if (a < NPTS) begin
      mx[a] = x;
      my[a] = y;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    #1;
    tick();
    tick();
    n_checks++; if (bus.LRST !== 1'b1) begin n_fail++; $display("FAIL reset_lrst: got %b want 1", bus.LRST); end
    n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
    n_checks++; if ({bus.X, bus.Y} !== 8'h00) begin n_fail++; $display("FAIL reset_xy: got %h want 00", {bus.X, bus.Y}); end
    n_checks++; if (bus.RES !== 16'h0000) begin n_fail++; $display("FAIL reset_res: got %h want 0000", bus.RES); end
    n_checks++; if ({bus.RES_VALID, bus.TIMEOUT} !== 2'b00) begin n_fail++; $display("FAIL reset_pulses: got %b want 00", {bus.RES_VALID, bus.TIMEOUT}); end
    RST = 1'b0;
    exp_res = 16'h0000;
    n_checks++; if (bus.LRST !== 1'b1) begin n_fail++; $display("FAIL release_lrst_hold: got %b want 1", bus.LRST); end
    tick();
    n_checks++; if (bus.LRST !== 1'b0) begin n_fail++; $display("FAIL release_lrst: got %b want 0", bus.LRST); end
    n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL release_busy: got %b want 0", bus.BUSY); end
  endtask

  // One full transaction: START, core reset, NPTS points, wait `delay` edges, then DONE.
  task automatic test_stream(input string tag, input int delay, input bit disturb, input bit wr_same,
                             input logic [3:0] c1x, input logic [3:0] c1y,
                             input logic [3:0] c2x, input logic [3:0] c2y);
    int a;
    bus.START = 1'b1;
    if (wr_same) begin
      a = $urandom_range(0, NPTS - 1);
      bus.WEN = 1'b1; bus.WADDR = 6'(a); bus.WX = 4'($urandom); bus.WY = 4'($urandom);
      mx[a] = bus.WX; my[a] = bus.WY;
    end
    tick();
    bus.START = 1'b0;
    bus.WEN   = 1'b0;
    n_checks++; if ({bus.LRST, bus.BUSY} !== 2'b11) begin n_fail++; $display("FAIL %s_crst: lrst,busy got %b want 11", tag, {bus.LRST, bus.BUSY}); end
    n_checks++; if ({bus.X, bus.Y} !== 8'h00) begin n_fail++; $display("FAIL %s_crst_xy: got %h want 00", tag, {bus.X, bus.Y}); end
    for (int k = 0; k < NPTS; k++) begin
      if (disturb && (k == 10)) begin
        bus.START = 1'b1; bus.DONE = 1'b1; bus.WEN = 1'b1;
        bus.WADDR = 6'($urandom_range(0, NPTS - 1)); bus.WX = 4'($urandom); bus.WY = 4'($urandom);
      end
      tick();
      bus.START = 1'b0; bus.DONE = 1'b0; bus.WEN = 1'b0;
      n_checks++; if ({bus.X, bus.Y} !== {mx[k], my[k]}) begin n_fail++; $display("FAIL %s_pt[%0d]: got %h want %h", tag, k, {bus.X, bus.Y}, {mx[k], my[k]}); end
      n_checks++; if ({bus.LRST, bus.BUSY, bus.RES_VALID} !== 3'b010) begin n_fail++; $display("FAIL %s_ctl[%0d]: lrst,busy,vld got %b want 010", tag, k, {bus.LRST, bus.BUSY, bus.RES_VALID}); end
    end
    tick();
    n_checks++; if ({bus.X, bus.Y} !== 8'h00) begin n_fail++; $display("FAIL %s_wait_xy: got %h want 00", tag, {bus.X, bus.Y}); end
    for (int i = 0; i < delay; i++) begin
      tick();
      n_checks++; if ({bus.BUSY, bus.RES_VALID, bus.TIMEOUT} !== 3'b100) begin n_fail++; $display("FAIL %s_wait[%0d]: busy,vld,to got %b want 100", tag, i, {bus.BUSY, bus.RES_VALID, bus.TIMEOUT}); end
    end
    bus.C1X = c1x; bus.C1Y = c1y; bus.C2X = c2x; bus.C2Y = c2y;
    bus.DONE = 1'b1;
    tick();
    bus.DONE = 1'b0;
    bus.C1X = 4'($urandom); bus.C1Y = 4'($urandom); bus.C2X = 4'($urandom); bus.C2Y = 4'($urandom);
    exp_res = {c1x, c1y, c2x, c2y};
    n_checks++; if (bus.RES !== exp_res) begin n_fail++; $display("FAIL %s_res: got %h want %h", tag, bus.RES, exp_res); end
    n_checks++; if ({bus.RES_VALID, bus.BUSY, bus.TIMEOUT} !== 3'b100) begin n_fail++; $display("FAIL %s_done: vld,busy,to got %b want 100", tag, {bus.RES_VALID, bus.BUSY, bus.TIMEOUT}); end
    tick();
    n_checks++; if (bus.RES_VALID !== 1'b0) begin n_fail++; $display("FAIL %s_vld_pulse: got %b want 0", tag, bus.RES_VALID); end
    n_checks++; if (bus.RES !== exp_res) begin n_fail++; $display("FAIL %s_res_hold: got %h want %h", tag, bus.RES, exp_res); end
  endtask

  task automatic test_pattern;
    for (int k = 0; k < NPTS; k++) write_point(k, 4'(k % 16), 4'(15 - k % 16));
    test_stream("pattern", 3, 1'b0, 1'b0, 4'd3, 4'd4, 4'd11, 4'd12);
    n_checks++; if (bus.RES !== 16'h34BC) begin n_fail++; $display("FAIL pattern_res_const: got %h want 34bc", bus.RES); end
  endtask

  task automatic test_ignored_writes;
    write_point(40, 4'hF, 4'hF);
    write_point(63, 4'hA, 4'h5);
    test_stream("disturb", $urandom_range(0, 10), 1'b1, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    test_stream("after_disturb", 1, 1'b0, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic test_same_cycle_write;
    test_stream("wen_start", 2, 1'b0, 1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic test_back_to_back;
    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 12; w++)
        write_point($urandom_range(0, 47), 4'($urandom), 4'($urandom));
      test_stream("b2b", $urandom_range(0, 10), 1'b0, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      test_stream("b2b_next", 0, 1'b0, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    end
  endtask

  task automatic test_reset_mid;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    for (int k = 0; k <= 20; k++) tick();
    RST = 1'b1;
    #1;
    exp_res = 16'h0000;
    n_checks++; if ({bus.LRST, bus.BUSY} !== 2'b10) begin n_fail++; $display("FAIL midrst_ctl: lrst,busy got %b want 10", {bus.LRST, bus.BUSY}); end
    n_checks++; if ({bus.X, bus.Y} !== 8'h00) begin n_fail++; $display("FAIL midrst_xy: got %h want 00", {bus.X, bus.Y}); end
    n_checks++; if (bus.RES !== exp_res) begin n_fail++; $display("FAIL midrst_res: got %h want 0000", bus.RES); end
    tick();
    RST = 1'b0;
    tick();
    for (int k = 0; k < NPTS; k++) write_point(k, 4'($urandom), 4'($urandom));
    test_stream("post_rst", 4, 1'b0, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
  endtask

`ifdef LASER_STREAM_TIMEOUT_EN
  task automatic test_timeout;
    logic [15:0] held;
    held = exp_res;
    bus.START = 1'b1;
    tick();
    bus.START = 1'b0;
    for (int k = 0; k <= NPTS; k++) tick();
    for (int i = 1; i < TO; i++) begin
      tick();
      n_checks++; if ({bus.TIMEOUT, bus.BUSY} !== 2'b01) begin n_fail++; $display("FAIL to_wait[%0d]: to,busy got %b want 01", i, {bus.TIMEOUT, bus.BUSY}); end
    end
    tick();
    n_checks++; if ({bus.TIMEOUT, bus.RES_VALID, bus.BUSY} !== 3'b100) begin n_fail++; $display("FAIL to_pulse: to,vld,busy got %b want 100", {bus.TIMEOUT, bus.RES_VALID, bus.BUSY}); end
    n_checks++; if (bus.RES !== held) begin n_fail++; $display("FAIL to_res: got %h want %h", bus.RES, held); end
    tick();
    n_checks++; if (bus.TIMEOUT !== 1'b0) begin n_fail++; $display("FAIL to_one_pulse: got %b want 0", bus.TIMEOUT); end
    test_stream("done_at_limit", TO - 1, 1'b0, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
  endtask
`else
  task automatic test_timeout;
    test_stream("long_wait", 60, 1'b0, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
  endtask
`endif

  initial begin
    RST = 1'b1;
    bus.WEN = 1'b0; bus.WADDR = '0; bus.WX = '0; bus.WY = '0; bus.START = 1'b0;
    bus.C1X = '0; bus.C1Y = '0; bus.C2X = '0; bus.C2Y = '0; bus.DONE = 1'b0;
    for (int k = 0; k < NPTS; k++) begin mx[k] = '0; my[k] = '0; end
    exp_res = '0;
    test_reset();
    test_pattern();
    test_ignored_writes();
    test_same_cycle_write();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/laser_point_streamer.md
# laser_point_streamer

Host-side driver for the laser treatment core: buffers one target set of NPTS (X,Y) points written by a host, then issues a one-cycle core reset and streams the points to the core on NPTS consecutive cycles. It waits for the core's DONE, captures the two circle centres, and presents them to the host with a valid pulse. It sits between the host/test harness and the laser core, driving the core's X/Y/RST inputs and consuming its C1X/C1Y/C2X/C2Y/DONE outputs.

## Interface
- NPTS, 40, number of points per set; buffer depth and stream length (1..63)
- TO_CYCLES, 4096, DONE wait limit in cycles (used only with LASER_STREAM_TIMEOUT_EN)
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  asynchronous, active-high reset
- WEN  in  1  host point write strobe
- WADDR  in  6  point index to write
- WX  in  4  point X to write
- WY  in  4  point Y to write
- START  in  1  one-cycle request to stream the buffered set
- BUSY  out  1  high from START acceptance until return to IDLE
- LRST  out  1  reset to laser core
- X  out  4  point X to core
- Y  out  4  point Y to core
- C1X, C1Y, C2X, C2Y  in  4 each  result from core
- DONE  in  1  core result valid
- RES  out  16  captured result {C1X,C1Y,C2X,C2Y}
- RES_VALID  out  1  one-cycle pulse, RES updated
- TIMEOUT  out  1  one-cycle pulse, DONE never arrived

## Operation
- Point buffer: NPTS entries of {X,Y}; not cleared by reset or by streaming.
- Write: WEN=1 in IDLE with WADDR<NPTS writes {WX,WY} at next edge; WEN while BUSY or WADDR>=NPTS ignored.
- States: IDLE, CRST, STREAM, WAIT_DONE.
- IDLE: BUSY=0, LRST=0, X=Y=0. START=1 -> CRST.
- CRST: one cycle; LRST=1, BUSY=1, X=Y=0; index cleared -> STREAM.
- STREAM: cycle k (k=0..NPTS-1) drives X,Y = buffer[k]; after k=NPTS-1 -> WAIT_DONE. DONE ignored here.
- WAIT_DONE: X=Y=0. DONE=1 sampled -> RES <= {C1X,C1Y,C2X,C2Y}, RES_VALID pulse next cycle, -> IDLE.
- START while BUSY ignored; no queueing.
- WEN and START in same IDLE cycle: write completes; stream uses the new value.
- RES holds last captured value until next capture; not changed by timeout.
- Index counter 6 bits, compares against NPTS-1, never wraps.

## Timing
- All outputs registered. Reset values: BUSY=0, LRST=1, X=0, Y=0, RES=0, RES_VALID=0, TIMEOUT=0, state IDLE.
- LRST drops to 0 on first edge after RST release; held high throughout RST assertion so the core stays reset.
- START at edge t -> CRST during cycle t+1 (LRST=1) -> point k on X/Y during cycle t+2+k.
- LRST high exactly one cycle, immediately followed by point 0; core samples point k at end of cycle t+2+k.
- DONE at edge d in WAIT_DONE -> RES and RES_VALID valid cycle d+1, BUSY=0 same cycle.
- RST mid-operation: immediate return to reset values, in-flight set abandoned, buffer contents preserved only as "don't care".

## Configuration
- LASER_STREAM_TIMEOUT_EN defined: counter runs in WAIT_DONE, cleared on entry; on reaching TO_CYCLES without DONE, TIMEOUT pulses one cycle, RES_VALID stays 0, -> IDLE. DONE on the same cycle the limit is reached wins (capture, no TIMEOUT).
- Not defined: no counter; WAIT_DONE waits indefinitely; TIMEOUT tied 0.

## Test plan
- Reset: RST=1 -> LRST=1, BUSY=0, X=Y=0, RES=0; release -> LRST=0 one edge later.
- Write points k -> (k%16, 15-k%16), START -> LRST=1 one cycle, then 40 cycles X=k%16, Y=15-k%16, then X=Y=0.
- Core model asserts DONE with C1=(3,4), C2=(11,12) -> RES=16'h34BC, RES_VALID one pulse, BUSY=0.
- START and WEN during STREAM -> stream unchanged, buffer unchanged, no restart; WADDR=40 in IDLE -> no write.
- RST asserted at stream point 20 -> immediate reset values; new START streams full 40 points.
- With LASER_STREAM_TIMEOUT_EN, TO_CYCLES=16, no DONE -> TIMEOUT pulse 16 cycles after WAIT_DONE entry, RES unchanged, IDLE.
